ping_pong_ctrl_n: RTL

PING_PONG_CTRL_N -- requirements
Module: ping_pong_ctrl_n

---
 rtl/top_pkg.sv | 16 +
 rtl/pp_bank_fsm.sv | 36 +++
 rtl/ping_pong_ctrl_n.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/top_pkg.sv
// Shared types for the ping-pong bank controller: per-bank state encoding and a
// width helper that never returns zero.
package top_pkg;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

  function automatic int unsigned width_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pp_bank_fsm.sv
// Occupancy state of one ping-pong bank, advanced by the write and read strobes
// that the controller steers onto this bank.
module pp_bank_fsm
  import top_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_fire,
  input  logic        wr_last,
  input  logic        rd_fire,
  input  logic        rd_last,
  output bank_state_t state
);

  bank_state_t state_q;
  bank_state_t state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:    if (wr_fire) state_d = wr_last ? FULL : FILLING;
      FILLING:  if (wr_fire && wr_last) state_d = FULL;
      FULL:     if (rd_fire) state_d = rd_last ? EMPTY : DRAINING;
      DRAINING: if (rd_fire && rd_last) state_d = EMPTY;
      default:  state_d = EMPTY;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/ping_pong_ctrl_n.sv
// Ping-pong controller for two single-port banks: a sliced producer fills one bank
// while the consumer drains the other. Optional error flags: PING_PONG_CTRL_N_ERR_EN.
module ping_pong_ctrl_n
  import top_pkg::*;
#(
  parameter int unsigned TOTAL_MODULES   = 1,
  parameter int unsigned WORDS_PER_SLICE = 16,
  parameter int unsigned ADDR_WIDTH      = $clog2(TOTAL_MODULES * WORDS_PER_SLICE)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  output logic [width_min1(TOTAL_MODULES)-1:0]     slicing_idx,
  output logic                                     bank0_ena,
  output logic                                     bank0_wea,
  output logic [ADDR_WIDTH-1:0]                    bank0_addra,
  output logic                                     bank1_ena,
  output logic                                     bank1_wea,
  output logic [ADDR_WIDTH-1:0]                    bank1_addra,
  input  logic                                     rd_en,
  output logic                                     rd_avail,
  output logic                                     out_valid,
  output logic                                     out_bank_sel,
  output logic                                     fill_done,
  output logic                                     drain_done
`ifdef PING_PONG_CTRL_N_ERR_EN
  ,
  output logic [1:0]                               err_sticky
`endif
);

  localparam int unsigned DEPTH   = TOTAL_MODULES * WORDS_PER_SLICE;
  localparam int unsigned SLICE_W = width_min1(TOTAL_MODULES);
  localparam int unsigned BEAT_W  = width_min1(WORDS_PER_SLICE);

  bank_state_t           bank_st [2];
  logic                  wr_sel;
  logic                  rd_sel;
  logic [SLICE_W-1:0]    slice_q;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic                  wr_fire;
  logic                  rd_fire;
  logic                  slice_last;
  logic                  beat_last;
  logic                  rd_last;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [1:0]            ena;
  logic [1:0]            wea;
  logic [ADDR_WIDTH-1:0] addr [2];

  // Handshake and pointer decode; every strobe is gated by rst_n so reset forces zeros.
  assign wr_fire    = rst_n && in_valid &&
                      ((bank_st[wr_sel] == EMPTY) || (bank_st[wr_sel] == FILLING));
  assign slice_last = (slice_q == SLICE_W'(TOTAL_MODULES - 1));
  assign beat_last  = (beat_cnt == BEAT_W'(WORDS_PER_SLICE - 1));
  assign in_ready   = wr_fire && slice_last;
  assign fill_done  = in_ready && beat_last;
  assign rd_avail   = rst_n &&
                      ((bank_st[rd_sel] == FULL) || (bank_st[rd_sel] == DRAINING));
  assign rd_fire    = rd_en && rd_avail;
  assign rd_last    = (rd_addr == ADDR_WIDTH'(DEPTH - 1));
  assign drain_done = rd_fire && rd_last;
  assign wr_addr    = ADDR_WIDTH'(slice_q * WORDS_PER_SLICE) + ADDR_WIDTH'(beat_cnt);
  assign slicing_idx = slice_q;

  // Write and read can only target different banks: a bank is writable or readable, never both.
  always_comb begin
    ena     = '0;
    wea     = '0;
    addr[0] = '0;
    addr[1] = '0;
    if (wr_fire) begin
      ena[wr_sel]  = 1'b1;
      wea[wr_sel]  = 1'b1;
      addr[wr_sel] = wr_addr;
    end
    if (rd_fire) begin
      ena[rd_sel]  = 1'b1;
      addr[rd_sel] = rd_addr;
    end
  end

  assign bank0_ena   = ena[0];
  assign bank0_wea   = wea[0];
  assign bank0_addra = addr[0];
  assign bank1_ena   = ena[1];
  assign bank1_wea   = wea[1];
  assign bank1_addra = addr[1];

  pp_bank_fsm u_bank0_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_fire (wr_fire && !wr_sel),
    .wr_last (fill_done),
    .rd_fire (rd_fire && !rd_sel),
    .rd_last (rd_last),
    .state   (bank_st[0])
  );

  pp_bank_fsm u_bank1_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_fire (wr_fire && wr_sel),
    .wr_last (fill_done),
    .rd_fire (rd_fire && rd_sel),
    .rd_last (rd_last),
    .state   (bank_st[1])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sel       <= 1'b0;
      rd_sel       <= 1'b0;
      slice_q      <= '0;
      beat_cnt     <= '0;
      rd_addr      <= '0;
      out_valid    <= 1'b0;
      out_bank_sel <= 1'b0;
    end else begin
      if (wr_fire) begin
        if (slice_last) begin
          slice_q <= '0;
          if (beat_last) begin
            beat_cnt <= '0;
            wr_sel   <= ~wr_sel;
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end else begin
          slice_q <= slice_q + SLICE_W'(1);
        end
      end
      if (rd_fire) begin
        if (rd_last) begin
          rd_addr <= '0;
          rd_sel  <= ~rd_sel;
        end else begin
          rd_addr <= rd_addr + ADDR_WIDTH'(1);
        end
      end
      // Bank RAMs have one cycle of read latency.
      out_valid    <= rd_fire;
      out_bank_sel <= rd_fire & rd_sel;
    end
  end

`ifdef PING_PONG_CTRL_N_ERR_EN
  localparam int unsigned STALL_LIMIT = 1024;
  logic [10:0] stall_cnt;

  // Sticky protocol errors: read of an unavailable bank, producer starved too long.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky <= '0;
      stall_cnt  <= '0;
    end else begin
      if (rd_en && !rd_avail) err_sticky[0] <= 1'b1;
      if (in_valid && !in_ready) begin
        if (stall_cnt == 11'(STALL_LIMIT)) err_sticky[1] <= 1'b1;
        else                              stall_cnt     <= stall_cnt + 11'd1;
      end else begin
        stall_cnt <= '0;
      end
    end
  end
`endif

endmodule
